// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receive/transmit path.
// Holds the receiver state encoding and the clocks-per-bit divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  // Clocks per bit for a given system clock and baud rate (truncating).
  function automatic int unsigned uart_clk_goal(input int unsigned clk_f,
                                                input int unsigned bps);
    return clk_f / bps;
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word stream with valid/ready handshake and the
// per-word status flags. The receiver drives it through the master modport.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: mid-bit tick generator shared by the UART receiver and
// transmitter. After i_start the first tick lands CLK_GOAL/2 cycles later,
// then one tick every CLK_GOAL cycles while i_enable stays high.
module uart_bit_timer #(
  parameter int CLK_GOAL = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_enable,
  output logic o_tick
);

  localparam int LP_CW = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
  localparam logic [LP_CW-1:0] LP_LAST = LP_CW'(CLK_GOAL - 1);
  // Preloading past zero makes the first wrap fall half a bit after start.
  localparam logic [LP_CW-1:0] LP_LOAD = LP_CW'(CLK_GOAL - CLK_GOAL / 2);

  logic [LP_CW-1:0] r_cnt;

  // Counter: preload on start, wrap at CLK_GOAL-1, park at zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= LP_LOAD;
    end else if (!i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable && (r_cnt == LP_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready word delivery.
// Optional parity is enabled by defining UART_RX_PARITY_EN; without it the
// frame is start + data + stop and parity_err is tied low.
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | half-bit wait, then confirm the start bit is still low
// DATA   | shifting DATA_BITS samples in, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling STOP_BITS stop bits, then delivering the word
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_F      = 50_000_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rxd,
  uart_rx_param_if.master rx,
  output logic            busy
);

  localparam int CLK_GOAL = int'(uart_clk_goal(CLK_F, UART_BPS));
  localparam int LP_BCW   = $clog2(DATA_BITS);
  localparam logic [LP_BCW-1:0] LP_DATA_LAST = LP_BCW'(DATA_BITS - 1);
  localparam logic [LP_BCW-1:0] LP_STOP_LAST = LP_BCW'(STOP_BITS - 1);

  // Elaboration-time parameter legality checks.
  if (CLK_GOAL < 4) begin : g_chk_goal
    $error("uart_rx_param: CLK_F / UART_BPS must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rxd_d;
  uart_rx_state_t       r_state;
  logic [LP_BCW-1:0]    r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr_acc;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_start_edge;
  logic                 w_tick;
  logic                 w_deliver;
`ifdef UART_RX_PARITY_EN
  localparam logic LP_ODD = 1'(PARITY_ODD);
  logic                 r_perr_acc;
  logic                 r_parity_err;
`endif

  // Two-flop synchroniser plus one edge register; all idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_rxd_d <= r_sync2;
    end
  end

  assign w_start_edge = (r_state == IDLE) && r_rxd_d && !r_sync2;
  // A finished word may load if the slot is empty or is being freed now.
  assign w_deliver    = !r_rx_valid || rx.rx_ready;

  uart_bit_timer #(
    .CLK_GOAL(CLK_GOAL)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start_edge),
    .i_enable(r_state != IDLE),
    .o_tick  (w_tick)
  );

  // Frame FSM with registered word, flags and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ferr_acc  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_acc   <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (r_rx_valid && rx.rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start_edge) begin
            r_state    <= START;
            r_ferr_acc <= 1'b0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_sync2) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == LP_DATA_LAST) begin
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= PARITY;
`else
              r_state   <= STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_perr_acc <= (^r_shift) ^ r_sync2 ^ LP_ODD;
            r_state    <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == LP_STOP_LAST) begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
              if (w_deliver) begin
                r_rx_data   <= r_shift;
                r_frame_err <= r_ferr_acc | !r_sync2;
                r_rx_valid  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= r_perr_acc;
`endif
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_bit_cnt  <= r_bit_cnt + 1'b1;
              r_ferr_acc <= r_ferr_acc | !r_sync2;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx.rx_data   = r_rx_data;
  assign rx.rx_valid  = r_rx_valid;
  assign rx.frame_err = r_frame_err;
  assign rx.overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign rx.parity_err = r_parity_err;
`else
  assign rx.parity_err = 1'b0;
`endif
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into uart_rx_param with a scoreboard
// queue of expected words popped by a handshake monitor.
module tb_uart_rx_param;
  localparam int CLK_F    = 1_000_000;
  localparam int UART_BPS = 100_000;
  localparam int GOAL     = 10;
  localparam int DB       = 8;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic uart_rxd = 1'b1;
  logic busy;

  uart_rx_param_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_param #(
    .CLK_F     (CLK_F),
    .UART_BPS  (UART_BPS),
    .DATA_BITS (DB),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rxd(uart_rxd),
    .rx      (rx_if.master),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   ovr_cnt  = 0;
  int   vld_cnt  = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every accepted word; count pulses.
  always @(negedge clk) begin
    if (rst_n && rx_if.rx_valid && rx_if.rx_ready) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: actual=%0h required=no word", rx_if.rx_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("rx_data", int'(rx_if.rx_data), int'(mon_e.data));
        check("frame_err", int'(rx_if.frame_err), int'(mon_e.ferr));
        check("parity_err", int'(rx_if.parity_err), int'(mon_e.perr));
      end
    end
    if (rx_if.overrun) ovr_cnt++;
    if (rx_if.rx_valid) vld_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic drive_bit(input logic b);
    @(negedge clk);
    uart_rxd = b;
    repeat (GOAL - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // par_flip inverts the correct even parity bit (parity builds only).
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
    drive_bit(stop_b);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb_q.size(), 0);
  endtask

  int v0, b0, o0;
  logic [7:0] abort_d;

  initial begin
    rx_if.rx_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_valid", int'(rx_if.rx_valid), 0);
    check("rst_rx_data", int'(rx_if.rx_data), 0);
    check("rst_frame_err", int'(rx_if.frame_err), 0);
    check("rst_parity_err", int'(rx_if.parity_err), 0);
    check("rst_overrun", int'(rx_if.overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    idle(20);

    // Plain frame, always ready: one-cycle valid.
    v0 = vld_cnt;
    sb_q.push_back('{8'hA5, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(20);
    wait_empty();
    check("a5_valid_cycles", vld_cnt - v0, 1);
    check("a5_valid_low", int'(rx_if.rx_valid), 0);

    // Short low glitch: false start.
    v0 = vld_cnt;
    b0 = busy_cnt;
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (3) @(negedge clk);
    uart_rxd = 1'b1;
    idle(30);
    check("glitch_busy_pulsed", int'(busy_cnt > b0), 1);
    check("glitch_busy_low", int'(busy), 0);
    check("glitch_no_valid", vld_cnt - v0, 0);

    // Bad stop bit, then good frame.
    sb_q.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(20);
    sb_q.push_back('{8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1);
    idle(20);
    wait_empty();

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: parity bit 0 is wrong under even parity.
    sb_q.push_back('{8'h07, 1'b0, 1'b1});
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    sb_q.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b0, 1'b1);
    idle(20);
    wait_empty();
`endif

    // Back-to-back frames with downstream stalled.
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b0;
    o0 = ovr_cnt;
    sb_q.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    check("overrun_pulses", ovr_cnt - o0, 1);
    check("held_valid", int'(rx_if.rx_valid), 1);
    check("held_data", int'(rx_if.rx_data), 'h11);
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b1;
    wait_empty();
    @(negedge clk);
    @(negedge clk);
    check("valid_fell", int'(rx_if.rx_valid), 0);

    // Hold a word, then reset during data bit 4 of the next frame.
    @(posedge clk);
    #1 rx_if.rx_ready = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1);
    idle(20);
    check("pre_reset_data", int'(rx_if.rx_data), 'hC3);
    abort_d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_d[i]);
    @(negedge clk);
    uart_rxd = abort_d[4];
    repeat (4) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rx_valid", int'(rx_if.rx_valid), 0);
    check("mid_rst_rx_data", int'(rx_if.rx_data), 0);
    check("mid_rst_frame_err", int'(rx_if.frame_err), 0);
    check("mid_rst_parity_err", int'(rx_if.parity_err), 0);
    check("mid_rst_overrun", int'(rx_if.overrun), 0);
    check("mid_rst_busy", int'(busy), 0);
    uart_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    idle(20);
    sb_q.push_back('{8'h5A, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(20);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the run never outlives its cycle budget.
  initial begin
    #(20000 * 10);
    total++;
    bad++;
    $display("FAIL watchdog: actual=timeout required=completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
